// File: rtl/ads_pkg.sv
// ads_pkg: shared types and reset values for the ads_target I2C register slave.
// Optional comparator is enabled with ADS_TGT_ALERT_EN (see ads_target).
package ads_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_MSB,
        WR_MSB_ACK,
        WR_LSB,
        WR_LSB_ACK,
        RD_MSB,
        RD_MSB_ACK,
        RD_LSB,
        RD_LSB_ACK
    } state_t;

    localparam logic [1:0] PTR_CONV = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;
    localparam logic [1:0] PTR_LO   = 2'd2;
    localparam logic [1:0] PTR_HI   = 2'd3;

    localparam logic [15:0] CONV_RST = 16'h0000;
    localparam logic [15:0] CFG_RST  = 16'h8583;
    localparam logic [15:0] LO_RST   = 16'h8000;
    localparam logic [15:0] HI_RST   = 16'h7FFF;

    function automatic logic is_ack(state_t s);
        return s inside {ADDR_ACK, PTR_ACK, WR_MSB_ACK, WR_LSB_ACK,
                         RD_MSB_ACK, RD_LSB_ACK};
    endfunction

endpackage

// File: rtl/ads_tgt_sync.sv
// ads_tgt_sync: SCL/SDA synchronizers with history flop, SCL edge and
// START/STOP strobes, all derived from synchronized values.
module ads_tgt_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // [0],[1] synchronizer stages, [2] history
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign sda      = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/ads_target.sv
// ads_target: I2C target with conversion/config/threshold registers.
// Define ADS_TGT_ALERT_EN to build the ALERT comparator with hysteresis.
module ads_target
    import ads_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] conv_data,
    input  logic        conv_load,
    output logic [15:0] config_out,
    output logic        alert_n
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    state_t      state;
    state_t      state_d;
    logic [3:0]  cnt;
    logic [3:0]  cnt_d;
    logic [7:0]  shift;
    logic [7:0]  wr_msb;
    logic [15:0] shadow;
    logic [15:0] conv_r;
    logic [15:0] cfg_r;
    logic [15:0] lo_r;
    logic [15:0] hi_r;
    logic [15:0] reg_sel;
    logic [15:0] rd_word;
    logic [1:0]  ptr;
    logic        ack_bit;
    logic        sda_oe_d;
    logic        in_ack;
    logic        byte_done;
    logic        ack_done;

    ads_tgt_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign in_ack    = is_ack(state);
    assign byte_done = scl_fall && !in_ack && state != IDLE && cnt == 4'd8;
    // cnt != 0 in an ACK state means the ninth SCL rise has been seen
    assign ack_done  = scl_fall && in_ack && cnt != 4'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (start) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
        end else if (state != IDLE) begin
            if (scl_rise) begin
                cnt_d = in_ack ? 4'd1 : cnt + 4'd1;
            end
            if (byte_done || ack_done) begin
                cnt_d = 4'd0;
                case (state)
                    ADDR:       state_d = (shift[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
                    ADDR_ACK:   state_d = shift[0] ? RD_MSB : PTR;
                    PTR:        state_d = PTR_ACK;
                    PTR_ACK:    state_d = WR_MSB;
                    WR_MSB:     state_d = WR_MSB_ACK;
                    WR_MSB_ACK: state_d = WR_LSB;
                    WR_LSB:     state_d = WR_LSB_ACK;
                    WR_LSB_ACK: state_d = WR_MSB;
                    RD_MSB:     state_d = RD_MSB_ACK;
                    RD_MSB_ACK: state_d = ack_bit ? IDLE : RD_LSB;
                    RD_LSB:     state_d = RD_LSB_ACK;
                    RD_LSB_ACK: state_d = ack_bit ? IDLE : RD_MSB;
                    default:    state_d = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (ptr)
            PTR_CONV: reg_sel = conv_r;
            PTR_CFG:  reg_sel = cfg_r;
            PTR_LO:   reg_sel = lo_r;
            default:  reg_sel = hi_r;
        endcase
    end

    // a new word is snapshotted on the same edge that leaves RD_LSB_ACK
    assign rd_word = (state == RD_LSB_ACK) ? reg_sel : shadow;

    always_comb begin
        sda_oe_d = 1'b0;
        case (state_d)
            ADDR_ACK,
            PTR_ACK,
            WR_MSB_ACK,
            WR_LSB_ACK: sda_oe_d = 1'b1;
            RD_MSB:     sda_oe_d = ~rd_word[{1'b1, ~cnt_d[2:0]}];
            RD_LSB:     sda_oe_d = ~rd_word[{1'b0, ~cnt_d[2:0]}];
            default:    sda_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sda_oe <= 1'b0;
        end else if (scl_fall || start || stop) begin
            sda_oe <= sda_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift   <= 8'h00;
            wr_msb  <= 8'h00;
            shadow  <= 16'h0000;
            ptr     <= PTR_CONV;
            ack_bit <= 1'b1;
            conv_r  <= CONV_RST;
            cfg_r   <= CFG_RST;
            lo_r    <= LO_RST;
            hi_r    <= HI_RST;
        end else begin
            if (conv_load) begin
                conv_r <= conv_data;
            end
            if (scl_rise && state != IDLE && !in_ack) begin
                shift <= {shift[6:0], sda_s};
            end
            if (scl_rise && in_ack) begin
                ack_bit <= sda_s;
            end
            if (byte_done && state == PTR) begin
                ptr <= shift[1:0];
            end
            if (byte_done && state == WR_MSB) begin
                wr_msb <= shift;
            end
            if (byte_done && state == ADDR && shift[0]) begin
                shadow <= reg_sel;
            end
            if (ack_done && state == RD_LSB_ACK) begin
                shadow <= reg_sel;
            end
            if (ack_done && state == WR_LSB_ACK) begin
                case (ptr)
                    PTR_CFG: cfg_r <= {wr_msb, shift};
                    PTR_LO:  lo_r  <= {wr_msb, shift};
                    PTR_HI:  hi_r  <= {wr_msb, shift};
                    default: ;
                endcase
            end
        end
    end

    assign config_out = cfg_r;

`ifdef ADS_TGT_ALERT_EN
    logic alert_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            alert_r <= 1'b1;
        end else if (conv_load) begin
            if ($signed(conv_data) >= $signed(hi_r)) begin
                alert_r <= 1'b0;
            end else if ($signed(conv_data) < $signed(lo_r)) begin
                alert_r <= 1'b1;
            end
        end
    end

    assign alert_n = alert_r;
`else
    assign alert_n = 1'b1;
`endif

endmodule

// File: tb/tb_ads_target.sv
// tb_ads_target: directed I2C master transactions against ads_target.
// Alert checks follow ADS_TGT_ALERT_EN.
module tb_ads_target;
    import ads_pkg::*;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        conv_load = 1'b0;
    logic [15:0] conv_data = 16'h0000;
    logic        sda_oe;
    logic [15:0] config_out;
    logic        alert_n;
    logic        sda_bus;
    logic        oe_clr = 1'b0;
    logic        oe_seen;
    int          total = 0;
    int          bad = 0;
    logic        a;
    logic [15:0] v;

    assign sda_bus = sda_m & ~sda_oe;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (oe_clr) oe_seen <= 1'b0;
        else if (sda_oe) oe_seen <= 1'b1;
    end

    ads_target #(.DEV_ADDR(7'h48)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .conv_data  (conv_data),
        .conv_load  (conv_load),
        .config_out (config_out),
        .alert_n    (alert_n)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic load(input logic [15:0] d);
        conv_data = d;
        conv_load = 1'b1;
        @(negedge clk);
        conv_load = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wq();
            scl_m = 1'b1; wq();
            scl_m = 1'b0; wq();
        end
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        ack = ~sda_bus;
        scl_m = 1'b0; wq();
    endtask

    task automatic rd_byte(input logic nack, input int load_at,
                           input logic [15:0] ld, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wq();
            scl_m = 1'b1; wq();
            b[i] = sda_bus;
            if (i == load_at) load(ld);
            scl_m = 1'b0; wq();
        end
        sda_m = nack; wq();
        scl_m = 1'b1; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic wr_reg(input logic [1:0] p, input logic [15:0] d);
        logic ack;
        i2c_start();
        wr_byte(8'h90, ack); chk("wr_addr_ack", {15'd0, ack}, 16'd1);
        wr_byte({6'd0, p}, ack); chk("wr_ptr_ack", {15'd0, ack}, 16'd1);
        wr_byte(d[15:8], ack); chk("wr_msb_ack", {15'd0, ack}, 16'd1);
        wr_byte(d[7:0], ack); chk("wr_lsb_ack", {15'd0, ack}, 16'd1);
        i2c_stop();
    endtask

    task automatic rd_reg(input logic [1:0] p, input int load_at,
                          input logic [15:0] ld, output logic [15:0] d);
        logic ack;
        logic [7:0] hi;
        logic [7:0] lo;
        i2c_start();
        wr_byte(8'h90, ack); chk("rd_waddr_ack", {15'd0, ack}, 16'd1);
        wr_byte({6'd0, p}, ack); chk("rd_ptr_ack", {15'd0, ack}, 16'd1);
        i2c_start();
        wr_byte(8'h91, ack); chk("rd_raddr_ack", {15'd0, ack}, 16'd1);
        rd_byte(1'b0, load_at, ld, hi);
        rd_byte(1'b1, -1, 16'h0000, lo);
        i2c_stop();
        d = {hi, lo};
    endtask

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b1;
        wq();
        chk("rst_cfg", config_out, 16'h8583);
        chk("rst_oe", {15'd0, sda_oe}, 16'd0);
        chk("rst_alert", {15'd0, alert_n}, 16'd1);
        chk("rst_state", {12'd0, dut.state}, {12'd0, IDLE});

        rd_reg(2'd0, -1, 16'h0, v); chk("rst_conv", v, 16'h0000);
        rd_reg(2'd2, -1, 16'h0, v); chk("rst_lo", v, 16'h8000);
        rd_reg(2'd3, -1, 16'h0, v); chk("rst_hi", v, 16'h7FFF);

        // config write with every ACK checked, value visible after last ACK
        i2c_start();
        wr_byte(8'h90, a); chk("cfg_addr_ack", {15'd0, a}, 16'd1);
        wr_byte(8'h01, a); chk("cfg_ptr_ack", {15'd0, a}, 16'd1);
        wr_byte(8'h12, a); chk("cfg_msb_ack", {15'd0, a}, 16'd1);
        wr_byte(8'h34, a); chk("cfg_lsb_ack", {15'd0, a}, 16'd1);
        chk("cfg_val", config_out, 16'h1234);
        i2c_stop();

        load(16'hABCD);
        rd_reg(2'd0, -1, 16'h0, v);
        chk("rd_conv", v, 16'hABCD);
        chk("rd_release", {15'd0, sda_oe}, 16'd0);

        // wrong address must never be acknowledged
        oe_clr = 1'b1; @(negedge clk); oe_clr = 1'b0;
        i2c_start();
        wr_byte(8'h92, a); chk("bad_addr_ack", {15'd0, a}, 16'd0);
        wr_byte(8'h01, a); chk("bad_ptr_ack", {15'd0, a}, 16'd0);
        wr_byte(8'h00, a); chk("bad_data_ack", {15'd0, a}, 16'd0);
        chk("bad_state", {12'd0, dut.state}, {12'd0, IDLE});
        i2c_stop();
        chk("bad_oe_seen", {15'd0, oe_seen}, 16'd0);
        chk("bad_cfg", config_out, 16'h1234);

        rd_reg(2'd0, 4, 16'h1111, v); chk("rd_inflight", v, 16'hABCD);
        rd_reg(2'd0, -1, 16'h0, v); chk("rd_after_load", v, 16'h1111);

        wr_reg(2'd0, 16'h5566);
        rd_reg(2'd0, -1, 16'h0, v); chk("conv_wr_discard", v, 16'h1111);

        // two words back to back on one pointer
        i2c_start();
        wr_byte(8'h90, a); wr_byte(8'h01, a);
        wr_byte(8'h12, a); wr_byte(8'hAA, a);
        chk("loop_first", config_out, 16'h12AA);
        wr_byte(8'h56, a); chk("loop_msb_ack", {15'd0, a}, 16'd1);
        wr_byte(8'h78, a); chk("loop_lsb_ack", {15'd0, a}, 16'd1);
        chk("loop_cfg", config_out, 16'h5678);
        i2c_stop();

        // reset in the middle of the LSB of a config write
        i2c_start();
        wr_byte(8'h90, a); wr_byte(8'h01, a);
        wr_byte(8'hFF, a); chk("abort_msb_ack", {15'd0, a}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            sda_m = 1'b0; wq();
            scl_m = 1'b1; wq();
            scl_m = 1'b0; wq();
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_cfg", config_out, 16'h8583);
        chk("abort_oe", {15'd0, sda_oe}, 16'd0);
        chk("abort_state", {12'd0, dut.state}, {12'd0, IDLE});
        reset = 1'b1;
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
        wr_reg(2'd1, 16'hBEEF);
        chk("abort_rewrite", config_out, 16'hBEEF);
        rd_reg(2'd0, -1, 16'h0, v); chk("abort_conv", v, 16'h0000);

`ifdef ADS_TGT_ALERT_EN
        wr_reg(2'd3, 16'h0100);
        wr_reg(2'd2, 16'h0080);
        load(16'h0200); chk("alert_hi", {15'd0, alert_n}, 16'd0);
        load(16'h00C0); chk("alert_hold", {15'd0, alert_n}, 16'd0);
        load(16'h0040); chk("alert_lo", {15'd0, alert_n}, 16'd1);
`else
        load(16'h7FFF); @(negedge clk);
        chk("alert_const", {15'd0, alert_n}, 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
